// File: rtl/serial_pkg.sv
// Shared definitions for the serial word collector: FSM state encoding and
// bit-counter sizing.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Enough bits to count from 0 up to and including width.
    function automatic int bitCountWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_collector_sipo_shift_reg.sv
// Serial-in parallel-out shift register holding the partial word; the shift
// direction is selected at build time.
module sipo_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] w_shifted;

    generate
        if (MSB_FIRST) begin : g_msbFirst
            assign w_shifted = {r_sreg[WIDTH-2:0], d};
        end else begin : g_lsbFirst
            assign w_shifted = {d, r_sreg[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sreg <= '0;
        end else if (shift_en) begin
            r_sreg <= w_shifted;
        end
    end

    assign q = r_sreg;

endmodule

// File: rtl/serial_word_collector.sv
// Assembles a qualified serial bit stream into WIDTH-bit words and presents
// them on a valid/ready handshake, with a sticky overrun flag for dropped bits.
module serial_word_collector
    import serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              d,
    input  logic                              d_valid,
    input  logic                              frame_start,
    output logic [WIDTH-1:0]                  word_out,
    output logic                              word_valid,
    input  logic                              word_ready,
    output logic [bitCountWidth(WIDTH)-1:0]   bit_count,
    output logic                              overrun
);

    localparam int CW = bitCountWidth(WIDTH);

    state_t           r_state;
    state_t           w_nextState;
    logic [CW-1:0]    r_bitCount;
    logic [CW-1:0]    w_nextCount;
    logic [CW-1:0]    w_countInc;
    logic [WIDTH-1:0] r_wordOut;
    logic             r_overrun;
    logic             w_accept;
    logic             w_latchWord;
    logic             w_dropBit;
    logic [WIDTH-1:0] w_partial;
    logic [WIDTH-1:0] w_nextWord;
    logic             w_unusedBit;

    assign w_accept   = d_valid & ((r_state != FULL) | word_ready);
    assign w_countInc = r_bitCount + CW'(1);

    sipo_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sipo (
        .clk      (clk),
        .reset    (reset),
        .shift_en (w_accept),
        .d        (d),
        .q        (w_partial)
    );

    // The output register captures the word as it will look after this
    // edge's shift, so word_out is valid in the same cycle as word_valid.
    generate
        if (MSB_FIRST) begin : g_msbWord
            assign w_nextWord  = {w_partial[WIDTH-2:0], d};
            assign w_unusedBit = w_partial[WIDTH-1];
        end else begin : g_lsbWord
            assign w_nextWord  = {d, w_partial[WIDTH-1:1]};
            assign w_unusedBit = w_partial[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_bitCount;
        w_latchWord = 1'b0;
        w_dropBit   = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_valid) begin
                    w_nextCount = CW'(1);
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (d_valid) begin
                    // A new frame abandons the partial word; stale bits are
                    // shifted out before the new word can complete.
                    if (frame_start) begin
                        w_nextCount = CW'(1);
                    end else if (w_countInc == CW'(WIDTH)) begin
                        w_nextCount = '0;
                        w_latchWord = 1'b1;
                        w_nextState = FULL;
                    end else begin
                        w_nextCount = w_countInc;
                    end
                end
            end
            FULL: begin
                if (word_ready) begin
                    if (d_valid) begin
                        w_nextCount = CW'(1);
                        w_nextState = SHIFT;
                    end else begin
                        w_nextState = IDLE;
                    end
                end else if (d_valid) begin
                    w_dropBit = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextCount = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bitCount <= '0;
            r_wordOut  <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_bitCount <= w_nextCount;
            if (w_latchWord) begin
                r_wordOut <= w_nextWord;
            end
            if (w_dropBit) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign word_out   = r_wordOut;
    assign word_valid = (r_state == FULL);
    assign bit_count  = r_bitCount;
    assign overrun    = r_overrun;

endmodule
